// File: rtl/io_timers.sv
// io_timers: 64-bit cycle counter with snapshot, millisecond uptime and NCH countdown channels on the j1 IO bus.
// Define IO_TIMERS_WATCHDOG_EN to turn channel 0 into a sticky watchdog that drives wdt_bite.
module io_timers #(
  parameter int unsigned MHZ  = 25,
  parameter int unsigned NCH  = 4,
  parameter logic [15:0] BASE = 16'h1010
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] mem_addr,
  input  logic [31:0] dout,
  output logic [31:0] din,
  output logic        irq,
  output logic        tick_ms,
  output logic        wdt_bite
);

  localparam logic [17:0] SUB_LAST = 18'(MHZ * 1000 - 1);
  localparam logic [31:0] HZ       = 32'(MHZ * 1000000);

  logic                 vld_p1;
  logic [15:0]          addr_p1;
  logic [31:0]          data_p1;
  logic [15:0]          woff;
  logic [15:0]          roff;
  logic [63:0]          counter;
  logic [63:0]          snap;
  logic [31:0]          ms;
  logic [17:0]          subms;
  logic [NCH-1:0][31:0] cnt_v;
  logic [NCH-1:0][5:0]  ctrl_v;
  logic [NCH-1:0]       irq_v;
  logic [NCH-1:0]       exp_v;
  logic [31:0]          rd_val;
  logic                 unused_sink;

  assign woff = addr_p1 - BASE;
  assign roff = mem_addr - BASE;

  // p0 -> p1: write strobe, address and data are registered before use
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= io_wr;
      addr_p1 <= mem_addr;
      data_p1 <= dout;
    end
  end

  // p1: timebase; the snapshot takes the counter value before this cycle's increment
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      counter <= '0;
      snap    <= '0;
      subms   <= '0;
      ms      <= '0;
      tick_ms <= 1'b0;
    end else begin
      counter <= counter + 64'd1;
      if (vld_p1 && (woff == 16'h0000))
        snap <= counter;
      if (subms == SUB_LAST) begin
        subms   <= '0;
        ms      <= ms + 32'd1;
        tick_ms <= 1'b1;
      end else begin
        subms   <= subms + 18'd1;
        tick_ms <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
`ifdef IO_TIMERS_WATCHDOG_EN
    localparam bit WDT_CH = (i == 0);
`else
    localparam bit WDT_CH = 1'b0;
`endif
    logic [31:0] cnt;
    logic [31:0] rel;
    logic        en;
    logic        per;
    logic        flag;
    logic        ien;
    logic        src;
    logic        wdt;
    logic        w_data;
    logic        w_ctrl;
    logic        tick;
    logic        expire;

    assign w_data = vld_p1 && (woff == 16'(16 + 8 * i));
    assign w_ctrl = vld_p1 && (woff == 16'(20 + 8 * i));
    assign tick   = src ? tick_ms : 1'b1;
    // A data write in the same cycle pre-empts the expiry, so no flag is raised
    assign expire = !w_data && en && tick && (cnt == 32'd1);

    always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
        cnt  <= '0;
        rel  <= '0;
        en   <= 1'b0;
        per  <= 1'b0;
        flag <= 1'b0;
        ien  <= 1'b0;
        src  <= 1'b0;
        wdt  <= 1'b0;
      end else begin
        if (w_data) begin
          cnt <= data_p1;
          rel <= data_p1;
        end else if (en && tick && (cnt != 32'd0)) begin
          cnt <= expire ? (per ? rel : 32'd0) : cnt - 32'd1;
        end
        if (w_ctrl) begin
          en  <= wdt ? (en | data_p1[0]) : data_p1[0];
          per <= data_p1[1];
          ien <= data_p1[3];
          src <= data_p1[4];
          wdt <= WDT_CH & (wdt | data_p1[5]);
        end
        flag <= expire | (flag & !(w_ctrl & data_p1[2]));
      end
    end

    assign cnt_v[i]  = cnt;
    assign ctrl_v[i] = {wdt, src, ien, flag, per, en};
    assign irq_v[i]  = flag & ien;
    assign exp_v[i]  = expire & wdt;
  end

  always_comb begin
    rd_val = '0;
    case (roff)
      16'h0000: rd_val = HZ;
      16'h0004: rd_val = snap[31:0];
      16'h0008: rd_val = snap[63:32];
      16'h000C: rd_val = ms;
      default:  rd_val = '0;
    endcase
    for (int i = 0; i < NCH; i++) begin
      if (roff == 16'(16 + 8 * i)) rd_val = cnt_v[i];
      if (roff == 16'(20 + 8 * i)) rd_val = {26'd0, ctrl_v[i]};
    end
  end

  // p1 -> p2: registered read data and interrupt
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      din <= '0;
      irq <= 1'b0;
    end else begin
      din <= rd_val;
      irq <= |irq_v;
    end
  end

`ifdef IO_TIMERS_WATCHDOG_EN
  logic [4:0] bite_cnt;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)
      bite_cnt <= '0;
    else if (|exp_v)
      bite_cnt <= 5'd16;
    else if (bite_cnt != 5'd0)
      bite_cnt <= bite_cnt - 5'd1;
  end

  assign wdt_bite    = (bite_cnt != 5'd0);
  assign unused_sink = io_rd;
`else
  assign wdt_bite    = 1'b0;
  assign unused_sink = io_rd ^ (|exp_v);
`endif

endmodule

// File: tb/tb_io_timers.sv
// Bench for io_timers: directed scenarios plus random bus traffic, all checked against a cycle-level reference model.
`timescale 1ns/1ps
module tb_io_timers;

  localparam int unsigned     MHZ  = 2;
  localparam int unsigned     NCH  = 4;
  localparam logic [15:0]     BASE = 16'h1010;
  localparam longint unsigned CPMS = MHZ * 1000;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [31:0] dout = '0;
  logic [31:0] din;
  logic        irq;
  logic        tick_ms;
  logic        wdt_bite;

  io_timers #(.MHZ(MHZ), .NCH(NCH), .BASE(BASE)) dut (
    .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr), .mem_addr(mem_addr),
    .dout(dout), .din(din), .irq(irq), .tick_ms(tick_ms), .wdt_bite(wdt_bite)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state; n counts clock edges since reset release
  longint unsigned n;
  longint unsigned m_snap;
  bit              p_wr;
  logic [15:0]     p_addr;
  logic [31:0]     p_data;
  int unsigned     m_cnt[NCH];
  int unsigned     m_rel[NCH];
  bit              m_en[NCH], m_per[NCH], m_flag[NCH], m_ien[NCH], m_src[NCH];
  bit              m_wdt;
  int              m_bite;
  bit              m_irq;
  logic [31:0]     m_din;

  int unsigned     seq[6] = '{3, 3, 2, 1, 0, 0};
  bit              found;
  int              cnt_a;
  longint unsigned nw;

  function automatic logic [15:0] ch_d(input int i);
    return BASE + 16'(16 + 8 * i);
  endfunction

  function automatic logic [15:0] ch_c(input int i);
    return BASE + 16'(20 + 8 * i);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; m_snap = 0; p_wr = 0; p_addr = '0; p_data = '0;
    m_wdt = 0; m_bite = 0; m_irq = 0; m_din = '0;
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_rel[i] = 0;
      m_en[i] = 0; m_per[i] = 0; m_flag[i] = 0; m_ien[i] = 0; m_src[i] = 0;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE;
    if (off == 16'h0) return 32'(MHZ * 1000000);
    if (off == 16'h4) return m_snap[31:0];
    if (off == 16'h8) return m_snap[63:32];
    if (off == 16'hC) return 32'(n / CPMS);
    for (int i = 0; i < NCH; i++) begin
      if (a == ch_d(i)) return m_cnt[i];
      if (a == ch_c(i))
        return {26'd0, (m_wdt && (i == 0)), m_src[i], m_ien[i], m_flag[i], m_per[i], m_en[i]};
    end
    return 32'd0;
  endfunction

  // one clock edge: read and irq see the old state, then the pending write and ticks apply
  task automatic model_edge();
    bit tk, ticked, wd, wc, expire;
    tk = (n > 0) && (n % CPMS == 0);
    m_din = model_read(mem_addr);
    m_irq = 0;
    for (int i = 0; i < NCH; i++) m_irq |= m_flag[i] & m_ien[i];
    if (p_wr && (p_addr == BASE)) m_snap = n;
    for (int i = 0; i < NCH; i++) begin
      ticked = m_src[i] ? tk : 1'b1;
      wd = p_wr && (p_addr == ch_d(i));
      wc = p_wr && (p_addr == ch_c(i));
      expire = 0;
      if (wd) begin
        m_cnt[i] = p_data;
        m_rel[i] = p_data;
      end else if (m_en[i] && ticked && m_cnt[i] != 0) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) begin
          expire = 1;
          if (m_per[i]) m_cnt[i] = m_rel[i];
        end
      end
      if (i == 0) begin
        if (expire && m_wdt) m_bite = 16;
        else if (m_bite > 0) m_bite--;
      end
      if (wc) begin
        if (p_data[2]) m_flag[i] = 0;
        m_en[i]  = (i == 0 && m_wdt) ? (m_en[i] | p_data[0]) : p_data[0];
        m_per[i] = p_data[1];
        m_ien[i] = p_data[3];
        m_src[i] = p_data[4];
`ifdef IO_TIMERS_WATCHDOG_EN
        if (i == 0) m_wdt = m_wdt | p_data[5];
`endif
      end
      if (expire) m_flag[i] = 1;
    end
    n++;
    p_wr = io_wr; p_addr = mem_addr; p_data = dout;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("din", din, m_din);
    chk("irq", irq, m_irq);
    chk("tick_ms", tick_ms, (n > 0) && (n % CPMS == 0));
    chk("wdt_bite", wdt_bite, m_bite > 0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    io_wr = 1'b1; mem_addr = a; dout = d;
    step();
    io_wr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    io_rd = 1'b1; mem_addr = a;
    step();
    io_rd = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_din", din, 0);
    chk("rst_irq", irq, 0);
    chk("rst_tick", tick_ms, 0);
    chk("rst_bite", wdt_bite, 0);
    resetq = 1'b1;

    // millisecond uptime and its tick
    mem_addr = BASE + 16'h0C;
    cnt_a = 0;
    repeat (int'(CPMS) + 20) begin
      step();
      cnt_a += int'(tick_ms);
      if (n == CPMS) chk("ms_before", din, 0);
      if (n == CPMS + 2) chk("ms_after", din, 1);
    end
    chk("tick_once", cnt_a, 1);

    rd(BASE);
    chk("hz_read", din, 32'(MHZ * 1000000));
    rd(BASE + 16'h30);
    chk("unmapped_30", din, 0);
    rd(BASE + 16'h02);
    chk("unmapped_02", din, 0);

    // snapshot holds the counter value of the cycle the write lands
    nw = n;
    wr(BASE, 32'hDEAD);
    step();
    rd(BASE + 16'h04);
    chk("snap_lo", din, 32'(nw + 1));
    repeat (5) step();
    rd(BASE + 16'h04);
    chk("snap_lo_hold", din, 32'(nw + 1));
    rd(BASE + 16'h08);
    chk("snap_hi", din, 32'((nw + 1) >> 32));

    // channel 0 one-shot on clk
    wr(ch_d(0), 3);
    wr(ch_c(0), 32'h09);
    mem_addr = ch_d(0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("ch0_seq", din, seq[k]);
    end
    chk("ch0_irq_set", irq, 1);
    rd(ch_c(0));
    chk("ch0_ctrl_flag", din, 32'h0D);
    wr(ch_c(0), 32'h04);
    step();
    step();
    chk("ch0_irq_clr", irq, 0);
    rd(ch_c(0));
    chk("ch0_ctrl_clr", din, 0);
    rd(ch_d(0));
    chk("ch0_cnt_hold", din, 0);

    // channel 1 periodic on tick_ms
    wr(ch_d(1), 2);
    wr(ch_c(1), 32'h13);
    mem_addr = ch_d(1);
    cnt_a = 0;
    repeat (4 * int'(CPMS) + 4) begin
      step();
      if (din != 1 && din != 2) cnt_a++;
    end
    chk("ch1_range", cnt_a, 0);
    rd(ch_c(1));
    chk("ch1_flag", din[2], 1);
    found = 0;
    for (int k = 0; k < 3 * int'(CPMS) && !found; k++) begin
      if (n % CPMS == 10) found = 1;
      else step();
    end
    chk("ch1_align", found, 1);
    wr(ch_c(1), 32'h17);
    found = 0;
    for (int k = 0; k < 4 * int'(CPMS) && !found; k++) begin
      if (m_cnt[1] == 1 && (n + 1) % CPMS == 0) found = 1;
      else step();
    end
    chk("ch1_expiry_wait", found, 1);
    wr(ch_d(1), 7);
    mem_addr = ch_c(1);
    step();
    step();
    chk("ch1_wr_beats_expiry", din, 32'h13);
    rd(ch_d(1));
    chk("ch1_new_cnt", din, 7);

    // channel 2 with reload 0 never flags
    wr(ch_d(2), 0);
    wr(ch_c(2), 32'h09);
    repeat (10) step();
    rd(ch_c(2));
    chk("ch2_no_flag", din, 32'h09);
    chk("ch2_no_irq", irq, 0);

    // channel 3: flag set wins over a coincident write-1-to-clear
    wr(ch_d(3), 5);
    wr(ch_c(3), 32'h01);
    repeat (4) step();
    wr(ch_c(3), 32'h05);
    step();
    rd(ch_c(3));
    chk("ch3_set_wins", din, 32'h05);

    // random bus traffic
    repeat (3000) begin
      int k;
      k = $urandom_range(0, 15);
      if (k < 4) mem_addr = BASE + 16'(4 * k);
      else if (k < 12) mem_addr = BASE + 16'(16 + 4 * (k - 4));
      else if (k == 12) mem_addr = BASE + 16'h02;
      else if (k == 13) mem_addr = BASE + 16'h30;
      else if (k == 14) mem_addr = BASE - 16'h04;
      else mem_addr = 16'($urandom);
      io_wr = ($urandom_range(0, 5) == 0);
      if (io_wr) begin
        k = $urandom_range(0, 2 * NCH);
        if (k == 2 * NCH) begin
          mem_addr = BASE; dout = $urandom;
        end else if (k % 2 == 0) begin
          mem_addr = ch_d(k / 2); dout = $urandom_range(0, 12);
        end else begin
          mem_addr = ch_c(k / 2); dout = $urandom & 32'h1F;
        end
      end
      step();
    end
    io_wr = 1'b0;

    // asynchronous reset with a write still in the pipeline
    wr(ch_d(0), 40);
    io_wr = 1'b1; mem_addr = ch_d(0); dout = 99;
    step();
    io_wr = 1'b0;
    resetq = 1'b0;
    #1;
    chk("rst2_din", din, 0);
    chk("rst2_irq", irq, 0);
    chk("rst2_tick", tick_ms, 0);
    repeat (2) @(posedge clk);
    #1;
    resetq = 1'b1;
    model_reset();
    rd(ch_d(0));
    step();
    chk("rst2_no_pending", din, 0);

`ifdef IO_TIMERS_WATCHDOG_EN
    wr(ch_d(0), 5);
    wr(ch_c(0), 32'h21);
    cnt_a = 0;
    repeat (60) begin
      step();
      cnt_a += int'(wdt_bite);
    end
    chk("wdt_bite_len", cnt_a, 16);
    wr(ch_c(0), 0);
    step();
    rd(ch_c(0));
    chk("wdt_en_sticky", din[0], 1);
    cnt_a = 0;
    repeat (10) begin
      wr(ch_d(0), 5);
      cnt_a += int'(wdt_bite);
      repeat (3) begin
        step();
        cnt_a += int'(wdt_bite);
      end
    end
    chk("wdt_fed", cnt_a, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
